instr_fetch: RTL and testbench

//  Fetch stage of the Octa16 core, directly upstream of the control decoder. Keeps the PC,

---
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Octa16 fetch stage: keeps the PC, assembles 16-bit instructions from two byte reads
// (high byte first) and hands the held word plus its func field to the decoder.
module instr_fetch #(
  parameter int unsigned        ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_ack,
  input  logic              branch_sel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic [15:0]       instr,
  output logic [3:0]        func,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [1:0] FETCH_HI = 2'd0;
  localparam logic [1:0] FETCH_LO = 2'd1;
  localparam logic [1:0] ISSUE    = 2'd2;
  localparam logic [1:0] FLUSH    = 2'd3;

  localparam logic [ADDR_W-1:0] EVEN_MASK = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_INIT   = RESET_PC & EVEN_MASK;

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [7:0]        hi, hi_nx;
  logic [15:0]       instr_nx;
  logic [3:0]        func_nx;
  logic              valid_nx;
  logic [ADDR_W-1:0] pc_out_nx;
  logic              req_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              ack_v;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_HI;
      pc          <= PC_INIT;
      hi          <= '0;
      instr       <= '0;
      func        <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      hi          <= hi_nx;
      instr       <= instr_nx;
      func        <= func_nx;
      instr_valid <= valid_nx;
      pc_out      <= pc_out_nx;
      imem_req    <= req_nx;
      imem_addr   <= addr_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    hi_nx     = hi;
    instr_nx  = instr;
    valid_nx  = instr_valid;
    pc_out_nx = pc_out;
    req_nx    = imem_req;
    addr_nx   = imem_addr;
    ack_v     = imem_ack & imem_req;

    case (state)
      FETCH_HI: begin
        if (ack_v) begin
          hi_nx    = imem_rdata;
          state_nx = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (ack_v) begin
          instr_nx  = {hi, imem_rdata};
          pc_out_nx = pc;
          valid_nx  = 1'b1;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          pc_nx    = pc + ADDR_W'(2);
          valid_nx = 1'b0;
          state_nx = FETCH_HI;
        end
      end
      FLUSH: begin
        if (ack_v) state_nx = FETCH_HI;
      end
      default: state_nx = FETCH_HI;
    endcase

    // Redirect wins; an unacked outstanding read must still drain through FLUSH
    if (branch_sel) begin
      pc_nx     = branch_target & EVEN_MASK;
      valid_nx  = 1'b0;
      hi_nx     = hi;
      instr_nx  = instr;
      pc_out_nx = pc_out;
      state_nx  = (imem_req && !imem_ack) ? FLUSH : FETCH_HI;
    end

    case (state_nx)
      FETCH_HI: begin
        req_nx  = 1'b1;
        addr_nx = pc_nx;
      end
      FETCH_LO: begin
        req_nx  = 1'b1;
        addr_nx = pc_nx + ADDR_W'(1);
      end
      FLUSH: begin
        req_nx  = 1'b1;
        addr_nx = imem_addr;
      end
      default: begin
        req_nx  = 1'b0;
        addr_nx = imem_addr;
      end
    endcase

    func_nx = instr_nx[15:12];
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: zero-wait and slow memory, stall, flush, redirect, wrap, reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        branch_sel, stall;
  logic [15:0] branch_target;

  logic        imem_req, imem_ack;
  logic [15:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic [15:0] instr;
  logic [3:0]  func;
  logic        instr_valid;
  logic [15:0] pc_out;

  logic        req2;
  logic [15:0] addr2;
  logic [7:0]  rdata2;
  logic [15:0] instr2;
  logic [3:0]  func2;
  logic        valid2;
  logic [15:0] pc_out2;

  logic [7:0]  mem [256];
  logic        mem_auto, man_ack;
  int          lat, cnt;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Memory responder: ack after lat wait cycles, or manual ack
  assign imem_ack   = mem_auto ? (imem_req && (cnt == lat)) : man_ack;
  assign imem_rdata = mem[imem_addr[7:0]];
  assign rdata2     = mem[addr2[7:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else                            cnt <= cnt + 1;
  end

  instr_fetch u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .branch_sel(branch_sel), .branch_target(branch_target), .stall(stall),
    .instr(instr), .func(func), .instr_valid(instr_valid), .pc_out(pc_out)
  );

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_dut2 (
    .clk(clk), .rst_n(rst2_n),
    .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2), .imem_ack(req2),
    .branch_sel(1'b0), .branch_target(16'h0000), .stall(1'b0),
    .instr(instr2), .func(func2), .instr_valid(valid2), .pc_out(pc_out2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    branch_sel = 1'b0; branch_target = '0; stall = 1'b0;
    mem_auto = 1'b1; lat = 0; man_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h00] = 8'h3A; mem[8'h01] = 8'h5C;
    mem[8'h40] = 8'hC1; mem[8'h41] = 8'h22;
    mem[8'h80] = 8'h7E; mem[8'h81] = 8'h0F;
    mem[8'hFE] = 8'h9B; mem[8'hFF] = 8'h17;

    repeat (2) step();
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_addr",  32'(imem_addr),   32'd0);
    check("rst_instr", 32'(instr),       32'd0);
    check("rst_func",  32'(func),        32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pcout", 32'(pc_out),      32'd0);
    rst_n = 1'b1;

    // zero-wait memory: 3 clocks per instruction
    step();
    check("t1_req0",  32'(imem_req),  32'd1);
    check("t1_addr0", 32'(imem_addr), 32'h0);
    step();
    check("t1_addr1", 32'(imem_addr), 32'h1);
    check("t1_nval",  32'(instr_valid), 32'd0);
    step();
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_instr", 32'(instr),       32'h3A5C);
    check("t1_func",  32'(func),        32'h3);
    check("t1_pcout", 32'(pc_out),      32'h0);
    check("t1_req_issue", 32'(imem_req), 32'd0);
    step();
    check("t1_next_req",  32'(imem_req),    32'd1);
    check("t1_next_addr", 32'(imem_addr),   32'h2);
    check("t1_consumed",  32'(instr_valid), 32'd0);

    // one wait cycle per byte: 5 clocks per instruction
    lat = 1;
    step();
    check("t2_hold_req",  32'(imem_req),  32'd1);
    check("t2_hold_addr", 32'(imem_addr), 32'h2);
    step();
    check("t2_addr_lo",   32'(imem_addr), 32'h3);
    step();
    check("t2_hold_lo",   32'(imem_addr), 32'h3);
    check("t2_nval",      32'(instr_valid), 32'd0);
    step();
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_instr", 32'(instr),       32'hA7A6);
    check("t2_pcout", 32'(pc_out),      32'h2);

    // stall holds the instruction
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_valid", 32'(instr_valid), 32'd1);
      check("t3_instr", 32'(instr),       32'hA7A6);
      check("t3_func",  32'(func),        32'hA);
      check("t3_req",   32'(imem_req),    32'd0);
      check("t3_pcout", 32'(pc_out),      32'h2);
    end
    stall = 1'b0;
    step();
    check("t3_next_addr", 32'(imem_addr),   32'h4);
    check("t3_next_req",  32'(imem_req),    32'd1);
    check("t3_consumed",  32'(instr_valid), 32'd0);

    // redirect during FETCH_LO with ack pending -> FLUSH
    mem_auto = 1'b0; man_ack = 1'b1;
    step();
    check("t4_addr_lo", 32'(imem_addr), 32'h5);
    man_ack = 1'b0; branch_sel = 1'b1; branch_target = 16'h0041;
    step();
    check("t4_flush_req",  32'(imem_req),    32'd1);
    check("t4_flush_addr", 32'(imem_addr),   32'h5);
    check("t4_flush_nval", 32'(instr_valid), 32'd0);
    branch_sel = 1'b0;
    step();
    check("t4_flush_hold", 32'(imem_addr),   32'h5);
    check("t4_flush_nv2",  32'(instr_valid), 32'd0);
    man_ack = 1'b1;
    step();
    check("t4_target_addr", 32'(imem_addr),   32'h40);
    check("t4_target_req",  32'(imem_req),    32'd1);
    check("t4_no_stale",    32'(instr_valid), 32'd0);
    man_ack = 1'b0; mem_auto = 1'b1; lat = 0;
    step();
    check("t4_addr_41", 32'(imem_addr),   32'h41);
    check("t4_no_stale2", 32'(instr_valid), 32'd0);
    step();
    check("t4_valid", 32'(instr_valid), 32'd1);
    check("t4_instr", 32'(instr),       32'hC122);
    check("t4_pcout", 32'(pc_out),      32'h40);

    // redirect with ack in the same cycle in FETCH_HI -> no FLUSH
    step();
    check("t5_addr_42", 32'(imem_addr), 32'h42);
    branch_sel = 1'b1; branch_target = 16'h0081;
    step();
    check("t5_target", 32'(imem_addr),   32'h80);
    check("t5_req",    32'(imem_req),    32'd1);
    check("t5_nval",   32'(instr_valid), 32'd0);
    branch_sel = 1'b0;
    step();
    check("t5_no_flush", 32'(imem_addr), 32'h81);
    step();
    check("t5_valid", 32'(instr_valid), 32'd1);
    check("t5_instr", 32'(instr),       32'h7E0F);
    check("t5_func",  32'(func),        32'h7);
    check("t5_pcout", 32'(pc_out),      32'h80);

    // redirect overrides stall in ISSUE
    stall = 1'b1;
    step();
    check("t5b_held", 32'(instr_valid), 32'd1);
    branch_sel = 1'b1; branch_target = 16'h0010;
    step();
    check("t5b_nval", 32'(instr_valid), 32'd0);
    check("t5b_req",  32'(imem_req),    32'd1);
    check("t5b_addr", 32'(imem_addr),   32'h10);
    branch_sel = 1'b0; stall = 1'b0;

    // RESET_PC odd/top of memory: wrap, then async reset mid-FETCH_LO
    rst2_n = 1'b1;
    step();
    check("t6_addr_fffe", 32'(addr2), 32'hFFFE);
    check("t6_req",       32'(req2),  32'd1);
    step();
    check("t6_addr_ffff", 32'(addr2), 32'hFFFF);
    step();
    check("t6_valid", 32'(valid2),  32'd1);
    check("t6_instr", 32'(instr2),  32'h9B17);
    check("t6_func",  32'(func2),   32'h9);
    check("t6_pcout", 32'(pc_out2), 32'hFFFE);
    step();
    check("t6_wrap_addr", 32'(addr2),  32'h0);
    check("t6_wrap_nval", 32'(valid2), 32'd0);
    step();
    check("t6_addr_lo", 32'(addr2), 32'h1);
    rst2_n = 1'b0;
    #1;
    check("t6_arst_req",   32'(req2),    32'd0);
    check("t6_arst_addr",  32'(addr2),   32'd0);
    check("t6_arst_instr", 32'(instr2),  32'd0);
    check("t6_arst_func",  32'(func2),   32'd0);
    check("t6_arst_valid", 32'(valid2),  32'd0);
    check("t6_arst_pcout", 32'(pc_out2), 32'd0);
    step();
    rst2_n = 1'b1;
    step();
    check("t6_restart", 32'(addr2), 32'hFFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
